// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory pipeline stage.
//   mem_size_t  : access size encoding driven by decode (byte/half/word)
//   mem_state_t : bus-access FSM states
//   is_misaligned() : natural-alignment test used when alignment checking is built in
package mem_stage_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned BE_WIDTH   = 4;
    localparam int unsigned REG_WIDTH  = 5;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CMD    = 2'd1,
        S_RDWAIT = 2'd2
    } mem_state_t;

    // True when the access is not naturally aligned for its size.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = addr_lo[0];
            default: is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Combinational byte-lane logic for the memory stage.
//   addr_lo    in  : low two address bits of the access
//   size       in  : access size
//   load_u     in  : zero-extend sub-word loads when set
//   store_data in  : raw store operand
//   rdata      in  : raw bus read data
//   be         out : byte enables for the access
//   wdata      out : store data replicated across lanes
//   load_data  out : lane-extracted, extended load result
// Half-word accesses ignore lane bit 0 and word accesses ignore the lane
// entirely, so low address bits are effectively forced aligned.
module mem_stage_align
    import mem_stage_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [1:0]  addr_lo,
    input  mem_size_t   size,
    input  logic        load_u,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [1:0]  lane;
    logic [1:0]  lane_h;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign lane   = BIG_ENDIAN ? (addr_lo ^ 2'b11) : addr_lo;
    assign lane_h = {lane[1], 1'b0};

    // Lane selection for loads.
    always_comb begin
        case (lane)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = lane_h[1] ? rdata[31:16] : rdata[15:0];
    end

    // Byte enables, store replication and load extension.
    always_comb begin
        be        = 4'hF;
        wdata     = store_data;
        load_data = rdata;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << lane;
                wdata     = {4{store_data[7:0]}};
                load_data = {{24{byte_v[7] & ~load_u}}, byte_v};
            end
            SZ_HALF: begin
                be        = 4'b0011 << lane_h;
                wdata     = {2{store_data[15:0]}};
                load_data = {{16{half_v[15] & ~load_u}}, half_v};
            end
            default: begin
                be        = 4'hF;
                wdata     = store_data;
                load_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: drives the data bus for loads/stores, stalls the
// pipe until the access completes, and registers results toward write-back.
//   clock, reset         : single clock, synchronous active-high reset
//   in_valid .. inval_dest_reg : EX/MEM instruction fields
//   stall                : hold EX/MEM and upstream (combinational)
//   dmem_*               : data-memory bus; requests are combinational
//   wb_*                 : registered MEM/WB outputs
// Build option MEM_ALIGN_CHECK_EN: misaligned half/word accesses skip the
// bus, retire in one cycle without a register write and raise wb_misalign.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [31:0]           ex_result,
    input  logic [31:0]           ex_result_2,
    input  logic                  load_inst,
    input  logic                  store_inst,
    input  logic [1:0]            mem_size,
    input  logic                  load_u,
    input  logic [4:0]            dest_reg,
    input  logic                  dest_reg_valid,
    input  logic                  inval_dest_reg,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]           dmem_wdata,
    output logic [3:0]            dmem_be,
    output logic                  dmem_rd,
    output logic                  dmem_wr,
    input  logic                  dmem_waitrequest,
    input  logic [31:0]           dmem_rdata,
    input  logic                  dmem_rdvalid,
`ifdef MEM_ALIGN_CHECK_EN
    output logic                  wb_misalign,
`endif
    output logic                  wb_valid,
    output logic [31:0]           wb_result,
    output logic [4:0]            wb_dest_reg,
    output logic                  wb_dest_reg_valid
);

    mem_state_t  state, state_next;
    mem_size_t   size;
    logic        misalign;
    logic        mem_op;
    logic        advance;
    logic [31:0] load_data;

    assign size = mem_size_t'(mem_size);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (load_inst | store_inst) & is_misaligned(size, ex_result[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign mem_op    = in_valid & (load_inst | store_inst) & ~misalign;
    assign dmem_addr = {ex_result[ADDR_WIDTH-1:2], 2'b00};

    mem_stage_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_align (
        .addr_lo    (ex_result[1:0]),
        .size       (size),
        .load_u     (load_u),
        .store_data (ex_result_2),
        .rdata      (dmem_rdata),
        .be         (dmem_be),
        .wdata      (dmem_wdata),
        .load_data  (load_data)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next state, bus requests and stall. The request is held in S_CMD
    // because stall freezes EX/MEM, keeping address/data/enables stable.
    always_comb begin
        state_next = state;
        dmem_rd    = 1'b0;
        dmem_wr    = 1'b0;
        stall      = 1'b0;
        case (state)
            S_IDLE, S_CMD: begin
                if (mem_op) begin
                    dmem_rd = load_inst;
                    dmem_wr = store_inst & ~load_inst;
                    if (dmem_waitrequest) begin
                        stall      = 1'b1;
                        state_next = S_CMD;
                    end else if (load_inst & ~dmem_rdvalid) begin
                        stall      = 1'b1;
                        state_next = S_RDWAIT;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_RDWAIT: begin
                if (dmem_rdvalid) state_next = S_IDLE;
                else              stall      = 1'b1;
            end
            default: state_next = S_IDLE;
        endcase
        if (reset) begin
            dmem_rd = 1'b0;
            dmem_wr = 1'b0;
            stall   = 1'b0;
        end
    end

    assign advance = in_valid & ~stall;

    // MEM/WB register.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_valid          <= 1'b0;
            wb_result         <= 32'h0;
            wb_dest_reg       <= 5'd0;
            wb_dest_reg_valid <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            wb_misalign       <= 1'b0;
`endif
        end else begin
            wb_valid <= advance;
            if (advance) begin
                wb_result         <= (load_inst & ~misalign) ? load_data : ex_result;
                wb_dest_reg       <= dest_reg;
                wb_dest_reg_valid <= dest_reg_valid & ~inval_dest_reg & ~misalign;
`ifdef MEM_ALIGN_CHECK_EN
                wb_misalign       <= misalign;
`endif
            end else begin
                wb_dest_reg_valid <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                wb_misalign       <= 1'b0;
`endif
            end
        end
    end

endmodule
